// File: rtl/key_event_if.sv
// Event handshake bundle between key_event_queue (master) and its consumer (slave).
interface key_event_if #(
   parameter int ADDR_W = 2
) ();
   logic              ev_valid;
   logic              ev_ready;
   logic [1:0]        ev_type;
   logic [3:0]        ev_value;
   logic              ev_keypad;
   logic [ADDR_W:0]   count;
   logic              overflow;
   logic              clr_overflow;

   modport master (
      output ev_valid, ev_type, ev_value, ev_keypad, count, overflow,
      input  ev_ready, clr_overflow
   );

   modport slave (
      input  ev_valid, ev_type, ev_value, ev_keypad, count, overflow,
      output ev_ready, clr_overflow
   );
endinterface

// File: rtl/key_event_queue.sv
// Converts KeyboardDecoder state into classified press events queued in a small FIFO.
module key_event_queue #(
   parameter int DEPTH  = 4,
   parameter int ADDR_W = 2
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [511:0] key_down,
   input  logic [8:0]   last_change,
   input  logic         key_valid,
   key_event_if.master  ev
);

   localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

   typedef enum logic [1:0] {
      EV_DIGIT = 2'd0,
      EV_SPACE = 2'd1,
      EV_ENTER = 2'd2,
      EV_BKSP  = 2'd3
   } ev_type_e;

   typedef struct packed {
      ev_type_e   etype;
      logic [3:0] value;
      logic       keypad;
   } entry_t;

   logic [511:0]    prev_down_q, prev_down_d;
   logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [ADDR_W:0] count_q, count_d;
   logic            overflow_q, overflow_d;
   entry_t          mem_q [DEPTH];
   entry_t          mem_d [DEPTH];

   logic   cls_ok;
   entry_t cls_entry;
   logic   press, push, pop, empty, full, drop;

   // Map the most recent scancode to an event class; unknown codes are not pushable.
   always_comb begin
      cls_ok           = 1'b1;
      cls_entry.etype  = EV_DIGIT;
      cls_entry.value  = 4'd0;
      cls_entry.keypad = 1'b0;
      case (last_change)
         9'h045: cls_entry.value = 4'd0;
         9'h016: cls_entry.value = 4'd1;
         9'h01E: cls_entry.value = 4'd2;
         9'h026: cls_entry.value = 4'd3;
         9'h025: cls_entry.value = 4'd4;
         9'h02E: cls_entry.value = 4'd5;
         9'h036: cls_entry.value = 4'd6;
         9'h03D: cls_entry.value = 4'd7;
         9'h03E: cls_entry.value = 4'd8;
         9'h046: cls_entry.value = 4'd9;
         9'h070: begin cls_entry.value = 4'd0; cls_entry.keypad = 1'b1; end
         9'h069: begin cls_entry.value = 4'd1; cls_entry.keypad = 1'b1; end
         9'h072: begin cls_entry.value = 4'd2; cls_entry.keypad = 1'b1; end
         9'h07A: begin cls_entry.value = 4'd3; cls_entry.keypad = 1'b1; end
         9'h06B: begin cls_entry.value = 4'd4; cls_entry.keypad = 1'b1; end
         9'h073: begin cls_entry.value = 4'd5; cls_entry.keypad = 1'b1; end
         9'h074: begin cls_entry.value = 4'd6; cls_entry.keypad = 1'b1; end
         9'h06C: begin cls_entry.value = 4'd7; cls_entry.keypad = 1'b1; end
         9'h075: begin cls_entry.value = 4'd8; cls_entry.keypad = 1'b1; end
         9'h07D: begin cls_entry.value = 4'd9; cls_entry.keypad = 1'b1; end
         9'h029: cls_entry.etype = EV_SPACE;
         9'h05A, 9'h15A: cls_entry.etype = EV_ENTER;
         9'h066: cls_entry.etype = EV_BKSP;
         default: cls_ok = 1'b0;
      endcase
   end

   // Edge detection, FIFO bookkeeping and sticky overflow.
   always_comb begin
      press = key_valid & key_down[last_change] & ~prev_down_q[last_change];
      empty = (count_q == '0);
      full  = (count_q == FULL_CNT);
      pop   = ev.ev_ready & ~empty;
      // A full FIFO still accepts a push when the head leaves in the same cycle.
      drop  = press & cls_ok & full & ~pop;
      push  = press & cls_ok & ~drop;

      prev_down_d = key_down;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      count_d     = count_q;
      overflow_d  = overflow_q;
      mem_d       = mem_q;

      if (push) begin
         mem_d[wr_ptr_q] = cls_entry;
         wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      if (push && !pop) begin
         count_d = count_q + 1'b1;
      end else if (pop && !push) begin
         count_d = count_q - 1'b1;
      end

      if (drop) begin
         overflow_d = 1'b1;
      end else if (ev.clr_overflow) begin
         overflow_d = 1'b0;
      end
   end

   // State registers; reset overrides every other input.
   always_ff @(posedge clk) begin
      if (rst) begin
         prev_down_q <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         overflow_q  <= 1'b0;
         mem_q       <= '{default: '0};
      end else begin
         prev_down_q <= prev_down_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         overflow_q  <= overflow_d;
         mem_q       <= mem_d;
      end
   end

   // Present the head entry, or zeros when nothing is queued.
   always_comb begin
      ev.ev_valid  = ~empty;
      ev.ev_type   = 2'd0;
      ev.ev_value  = 4'd0;
      ev.ev_keypad = 1'b0;
      if (!empty) begin
         ev.ev_type   = mem_q[rd_ptr_q].etype;
         ev.ev_value  = mem_q[rd_ptr_q].value;
         ev.ev_keypad = mem_q[rd_ptr_q].keypad;
      end
      ev.count    = count_q;
      ev.overflow = overflow_q;
   end

endmodule

// File: tb/tb_key_event_queue.sv
// Directed bench for key_event_queue with a queue-based reference model.
module tb_key_event_queue;

   localparam int DEPTH = 4;

   logic         clk = 1'b0;
   logic         rst;
   logic [511:0] kd;
   logic [8:0]   lc;
   logic         kv;

   key_event_if #(.ADDR_W(2)) ev_if ();

   key_event_queue #(.DEPTH(DEPTH), .ADDR_W(2)) dut (
      .clk         (clk),
      .rst         (rst),
      .key_down    (kd),
      .last_change (lc),
      .key_valid   (kv),
      .ev          (ev_if)
   );

   always #5 clk = ~clk;

   int n_total = 0;
   int n_pass  = 0;
   bit chk_en  = 1'b0;

   task automatic chk(input string name, input int act, input int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
   endtask

   // ---------------- reference model ----------------
   typedef struct {
      int t;
      int v;
      int kp;
   } mev_t;

   mev_t         m_q[$];
   logic [511:0] m_prev;
   int           m_ovf;

   function automatic bit classify(input logic [8:0] code, output mev_t e);
      logic [8:0] top [10] = '{9'h045, 9'h016, 9'h01E, 9'h026, 9'h025,
                               9'h02E, 9'h036, 9'h03D, 9'h03E, 9'h046};
      logic [8:0] kpd [10] = '{9'h070, 9'h069, 9'h072, 9'h07A, 9'h06B,
                               9'h073, 9'h074, 9'h06C, 9'h075, 9'h07D};
      e = '{t: 0, v: 0, kp: 0};
      for (int i = 0; i < 10; i++) begin
         if (code == top[i]) begin e = '{t: 0, v: i, kp: 0}; return 1'b1; end
         if (code == kpd[i]) begin e = '{t: 0, v: i, kp: 1}; return 1'b1; end
      end
      if (code == 9'h029) begin e.t = 1; return 1'b1; end
      if (code == 9'h05A || code == 9'h15A) begin e.t = 2; return 1'b1; end
      if (code == 9'h066) begin e.t = 3; return 1'b1; end
      return 1'b0;
   endfunction

   always @(posedge clk) begin
      mev_t e;
      bit   ok, prs, dopop, set;
      if (rst) begin
         m_q.delete();
         m_prev = '0;
         m_ovf  = 0;
      end else begin
         ok    = classify(lc, e);
         prs   = kv && kd[lc] && !m_prev[lc];
         dopop = ev_if.ev_ready && (m_q.size() > 0);
         set   = 1'b0;
         if (dopop) void'(m_q.pop_front());
         if (prs && ok) begin
            if (m_q.size() >= DEPTH) set = 1'b1;
            else m_q.push_back(e);
         end
         if (set) m_ovf = 1;
         else if (ev_if.clr_overflow) m_ovf = 0;
         m_prev = kd;
      end
   end

   // Every-cycle comparison against the model.
   always @(negedge clk) begin
      if (chk_en) begin
         int sz;
         sz = m_q.size();
         chk("ev_valid", int'(ev_if.ev_valid), (sz > 0) ? 1 : 0);
         chk("count", int'(ev_if.count), sz);
         chk("overflow", int'(ev_if.overflow), m_ovf);
         chk("ev_type", int'(ev_if.ev_type), (sz > 0) ? m_q[0].t : 0);
         chk("ev_value", int'(ev_if.ev_value), (sz > 0) ? m_q[0].v : 0);
         chk("ev_keypad", int'(ev_if.ev_keypad), (sz > 0) ? m_q[0].kp : 0);
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #1;
      rst                = 1'b0;
      kv                 = 1'b0;
      ev_if.ev_ready     = 1'b0;
      ev_if.clr_overflow = 1'b0;
   endtask

   task automatic press(input logic [8:0] code, input logic rdy, input logic clr);
      kd[code]           = 1'b1;
      lc                 = code;
      kv                 = 1'b1;
      ev_if.ev_ready     = rdy;
      ev_if.clr_overflow = clr;
      tick();
   endtask

   task automatic strobe(input logic [8:0] code);
      lc = code;
      kv = 1'b1;
      tick();
   endtask

   task automatic release_key(input logic [8:0] code);
      kd[code] = 1'b0;
      strobe(code);
   endtask

   task automatic pop(input logic clr);
      ev_if.ev_ready     = 1'b1;
      ev_if.clr_overflow = clr;
      tick();
   endtask

   task automatic head(input string name, input int t, input int v, input int kp);
      chk({name, ".type"}, int'(ev_if.ev_type), t);
      chk({name, ".value"}, int'(ev_if.ev_value), v);
      chk({name, ".keypad"}, int'(ev_if.ev_keypad), kp);
   endtask

   task automatic release_all();
      kd = '0;
      tick();
   endtask

   initial begin
      rst = 1'b1; kd = '0; lc = '0; kv = 1'b0;
      ev_if.ev_ready = 1'b0; ev_if.clr_overflow = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      tick();
      chk_en = 1'b1;
      chk("rst.count", int'(ev_if.count), 0);
      chk("rst.valid", int'(ev_if.ev_valid), 0);
      chk("rst.ovf", int'(ev_if.overflow), 0);

      // First press of top-row '1'
      press(9'h016, 1'b0, 1'b0);
      chk("p1.valid", int'(ev_if.ev_valid), 1);
      head("p1", 0, 1, 0);
      chk("p1.count", int'(ev_if.count), 1);
      // Typematic repeats and release produce nothing
      repeat (3) strobe(9'h016);
      release_key(9'h016);
      chk("rep.count", int'(ev_if.count), 1);
      pop(1'b0);
      chk("pop1.count", int'(ev_if.count), 0);
      // ev_ready on empty is ignored
      pop(1'b0);
      chk("empty_pop.count", int'(ev_if.count), 0);

      // One of each class, in order
      press(9'h07D, 1'b0, 1'b0);
      press(9'h029, 1'b0, 1'b0);
      press(9'h15A, 1'b0, 1'b0);
      press(9'h066, 1'b0, 1'b0);
      chk("mix.count", int'(ev_if.count), 4);
      head("mix0", 0, 9, 1); pop(1'b0);
      head("mix1", 1, 0, 0); pop(1'b0);
      head("mix2", 2, 0, 0); pop(1'b0);
      head("mix3", 3, 0, 0); pop(1'b0);
      chk("mix.drained", int'(ev_if.ev_valid), 0);
      release_all();

      // Overflow on full, then clear alongside a pop
      press(9'h016, 1'b0, 1'b0);
      press(9'h01E, 1'b0, 1'b0);
      press(9'h026, 1'b0, 1'b0);
      press(9'h025, 1'b0, 1'b0);
      press(9'h045, 1'b0, 1'b0);
      chk("full.count", int'(ev_if.count), 4);
      chk("full.ovf", int'(ev_if.overflow), 1);
      pop(1'b1);
      chk("clr.ovf", int'(ev_if.overflow), 0);
      chk("clr.count", int'(ev_if.count), 3);
      // Refill, then push+pop while full
      press(9'h02E, 1'b0, 1'b0);
      press(9'h03E, 1'b1, 1'b0);
      chk("pp.count", int'(ev_if.count), 4);
      chk("pp.ovf", int'(ev_if.overflow), 0);
      head("pp0", 0, 3, 0); pop(1'b0);
      head("pp1", 0, 4, 0); pop(1'b0);
      head("pp2", 0, 5, 0); pop(1'b0);
      head("tail", 0, 8, 0); pop(1'b0);
      release_all();

      // Push together with ready on empty: no bypass
      press(9'h06B, 1'b1, 1'b0);
      chk("nobypass.count", int'(ev_if.count), 1);
      head("nobypass", 0, 4, 1);
      pop(1'b0);

      // Unmapped code
      press(9'h01C, 1'b0, 1'b0);
      chk("unmapped.valid", int'(ev_if.ev_valid), 0);
      chk("unmapped.ovf", int'(ev_if.overflow), 0);

      // Set beats clear in the same cycle
      press(9'h036, 1'b0, 1'b0);
      press(9'h03D, 1'b0, 1'b0);
      press(9'h046, 1'b0, 1'b0);
      press(9'h05A, 1'b0, 1'b0);
      press(9'h072, 1'b0, 1'b1);
      chk("setwins.ovf", int'(ev_if.overflow), 1);
      release_all();

      // Reset mid-operation with three queued
      pop(1'b1);
      chk("pre_rst.count", int'(ev_if.count), 3);
      rst = 1'b1;
      press(9'h074, 1'b1, 1'b0);
      chk("mid_rst.count", int'(ev_if.count), 0);
      chk("mid_rst.valid", int'(ev_if.ev_valid), 0);
      chk("mid_rst.ovf", int'(ev_if.overflow), 0);
      tick();
      tick();

      chk_en = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
